fpga_config_loader: RTL and testbench
=====================================

Name: fpga_config_loader

Overview:
Streaming configuration controller for the LUT/switch-box fabric. It replaces hierarchical pokes of LUT `mem` and switch-box `configure` registers with a valid/ready word stream. Each accepted word is decoded into an addressed write strobe towards the fabric, with per-LUT register-mode bits loaded in a dedicated phase. A trailer XOR checksum is verified, and `fabric_en` is raised only after a clean load.
- Parametrised in LUT count, switch-box count and word width.
- Sits between the bitstream source (testbench or host) and the fabric instance.

Parameters:
- N_LUT, 11, number of LUT cells in the fabric
- N_SB, 20, number of switch boxes
- WORD_W, 32, configuration word width; LUT truth table and SB config word are both WORD_W bits
- ADDR_W, 5, write address width; must satisfy 2^ADDR_W >= max(N_LUT, N_SB)

Ports:
- clock, input, 1, rising-edge system clock
- reset_n, input, 1, asynchronous active-low reset
- start, input, 1, single-cycle pulse that begins a load
- cfg_data, input, WORD_W, configuration stream word
- cfg_valid, input, 1, cfg_data valid
- cfg_ready, output, 1, loader accepts a word this cycle
- wr_en, output, 1, write strobe to the fabric
- wr_sel, output, 2, write target: 0 = LUT table, 1 = SB config, 2 = LUT mode bit
- wr_addr, output, ADDR_W, LUT or SB index
- wr_data, output, WORD_W, word to write; for wr_sel = 2 only bit WORD_W-1 is used (the LUT register-select bit)
- busy, output, 1, load in progress
- done, output, 1, load completed with a good checksum (level)
- error, output, 1, checksum mismatch (level)
- fabric_en, output, 1, fabric enabled for operation
- word_count, output, 8, number of words accepted in the current load

Behaviour:
- Reset (asynchronous, reset_n = 0): state IDLE; all outputs are 0; internal index and XOR accumulator are cleared. Reset mid-load discards the partial load, with no further writes.
- States: IDLE, LOAD_LUT, LOAD_SB, LOAD_MODE, CHECK, DONE, ERROR.
- Stream order is fixed. Total words = 2*N_LUT + N_SB + 1 (43 at defaults).
  - N_LUT truth tables
  - N_SB switch-box words
  - N_LUT mode words
  - 1 trailer word
- Transitions:
  - IDLE / DONE / ERROR + start -> LOAD_LUT. Index, accumulator and word_count are cleared; done, error and fabric_en drop to 0 on the next edge.
  - LOAD_LUT -> LOAD_SB after word N_LUT-1 is accepted.
  - LOAD_SB -> LOAD_MODE after word N_SB-1 is accepted.
  - LOAD_MODE -> CHECK after word N_LUT-1 is accepted.
  - CHECK: the trailer word is accepted and compared with the accumulator. Match -> DONE (done = 1, fabric_en = 1). Mismatch -> ERROR (error = 1, fabric_en = 0).
  - A start pulse in any LOAD_* or CHECK state is ignored.
- Handshake:
  - cfg_ready = 1 exactly in LOAD_LUT, LOAD_SB, LOAD_MODE and CHECK.
  - A transfer occurs when cfg_valid && cfg_ready.
  - cfg_valid may drop for any number of cycles; state and index hold, and no write is issued.
  - cfg_ready does not depend combinationally on cfg_valid.
- Write latency:
  - wr_en is registered and pulses for one cycle, on the cycle after each accepted non-trailer word.
  - wr_sel, wr_addr and wr_data are registered with wr_en and hold their last value otherwise.
  - The trailer produces no write.
- Indexing: wr_addr counts 0..N-1 within each phase and restarts at 0 on every phase change.
- Checksum: accumulator = XOR of every accepted non-trailer word, updated on acceptance.
- word_count:
  - Increments on each transfer, trailer included.
  - Reads 2*N_LUT + N_SB + 1 in DONE or ERROR.
  - Saturates at 255.
- busy = 1 in LOAD_* and CHECK states.
- done and error are never both 1.

Decomposition:
- Package fpga_cfg_pkg holds:
  - wr_sel encodings (SEL_LUT = 2'd0, SEL_SB = 2'd1, SEL_MODE = 2'd2)
  - the state encoding constants
  - default N_LUT, N_SB, WORD_W
  - a total-words constant function
- Sub-module cfg_xor_accum (WORD_W): clear input, accumulate-enable input, data input, registered XOR output, asynchronous active-low reset. Everything else stays in the top FSM.

Test Plan:
- Defaults; start, then 42 words of 0x00000000 and trailer 0x00000000 with cfg_valid held high -> 42 wr_en pulses, done = 1, fabric_en = 1, word_count = 43, error = 0.
- Word k = k+1 for k = 0..41 (word 0 = 0x00000001), trailer = XOR of those words -> done = 1. Check the write sequence:
  - LUT: wr_sel = 0, wr_addr 0..10
  - SB: wr_sel = 1, wr_addr 0..19
  - mode: wr_sel = 2, wr_addr 0..10
- Same stream with the trailer XOR 0x1 -> error = 1, fabric_en = 0, done = 0. A new start then a good stream -> done = 1, error = 0.
- Random cfg_valid gaps of 0-5 cycles -> write sequence identical to the gap-free run; no wr_en on idle cycles.
- reset_n low after word 15 -> all outputs 0 asynchronously. A new start and full stream -> correct done and a full write set.
- start pulse while at word 20 -> ignored, with word_count and wr_addr continuing unchanged. start from DONE -> fabric_en = 0 the next cycle and word_count = 0.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the fabric configuration loader.
// Covers write-target encodings, loader states, default geometry and the stream length helper.
package fpga_cfg_pkg;

  localparam int DEF_N_LUT  = 11;
  localparam int DEF_N_SB   = 20;
  localparam int DEF_WORD_W = 32;

  localparam logic [1:0] SEL_LUT  = 2'd0;
  localparam logic [1:0] SEL_SB   = 2'd1;
  localparam logic [1:0] SEL_MODE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_LUT,
    ST_LOAD_SB,
    ST_LOAD_MODE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Truth tables, switch boxes, mode words, then one trailer word.
  function automatic int totalWords(input int nLut, input int nSb);
    return 2 * nLut + nSb + 1;
  endfunction

endpackage

// File: rtl/cfg_xor_accum.sv
// Running XOR of accepted configuration words, used as the stream checksum.
module cfg_xor_accum #(
  parameter int WORD_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              acc_en_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] acc_o
);

  logic [WORD_W-1:0] acc_q;
  logic [WORD_W-1:0] acc_d;

  // A clear arriving together with an enable wins, so a new load always starts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fpga_config_loader.sv
// Streaming configuration loader: decodes a valid/ready word stream into fabric write strobes
// and enables the fabric only after the trailer checksum matches.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int N_LUT  = DEF_N_LUT,
  parameter int N_SB   = DEF_N_SB,
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              wr_en,
  output logic [1:0]        wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              fabric_en,
  output logic [7:0]        word_count
);

  localparam logic [ADDR_W-1:0] LUT_LAST = ADDR_W'(N_LUT - 1);
  localparam logic [ADDR_W-1:0] SB_LAST  = ADDR_W'(N_SB - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [1:0]        wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;

  logic              xfer;
  logic              accClear;
  logic              accEn;
  logic [WORD_W-1:0] accValue;
  logic [1:0]        phaseSel;
  logic [ADDR_W-1:0] phaseLast;
  state_e            phaseNext;

  cfg_xor_accum #(
    .WORD_W (WORD_W)
  ) u_accum (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (accClear),
    .acc_en_i (accEn),
    .data_i   (cfg_data),
    .acc_o    (accValue)
  );

  assign cfg_ready = (state_q == ST_LOAD_LUT) || (state_q == ST_LOAD_SB) ||
                     (state_q == ST_LOAD_MODE) || (state_q == ST_CHECK);
  assign xfer      = cfg_valid && cfg_ready;

  // Per-phase write target, last index and successor state for the three load phases.
  always_comb begin
    phaseSel  = SEL_LUT;
    phaseLast = LUT_LAST;
    phaseNext = ST_LOAD_SB;
    case (state_q)
      ST_LOAD_SB: begin
        phaseSel  = SEL_SB;
        phaseLast = SB_LAST;
        phaseNext = ST_LOAD_MODE;
      end
      ST_LOAD_MODE: begin
        phaseSel  = SEL_MODE;
        phaseLast = LUT_LAST;
        phaseNext = ST_CHECK;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    accClear  = 1'b0;
    accEn     = 1'b0;

    if (xfer && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d  = ST_LOAD_LUT;
          idx_d    = '0;
          count_d  = '0;
          accClear = 1'b1;
        end
      end
      ST_LOAD_LUT, ST_LOAD_SB, ST_LOAD_MODE: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_sel_d  = phaseSel;
          wr_addr_d = idx_q;
          wr_data_d = cfg_data;
          accEn     = 1'b1;
          if (idx_q == phaseLast) begin
            idx_d   = '0;
            state_d = phaseNext;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          state_d = (cfg_data == accValue) ? ST_DONE : ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_sel     = wr_sel_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = cfg_ready;
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign fabric_en  = (state_q == ST_DONE);
  assign word_count = count_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Self-checking bench for fpga_config_loader: table-driven full loads against a stream model,
// plus hand-written reset, ignored-start and restart-from-DONE sequences.
module tb_fpga_config_loader;

  localparam int N_LUT  = 11;
  localparam int N_SB   = 20;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 5;
  localparam int TOTAL  = 2 * N_LUT + N_SB + 1;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [WORD_W-1:0] cfg_data = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic              wr_en;
  logic [1:0]        wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              error;
  logic              fabric_en;
  logic [7:0]        word_count;

  fpga_config_loader #(
    .N_LUT  (N_LUT),
    .N_SB   (N_SB),
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .fabric_en  (fabric_en),
    .word_count (word_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wrRec_t;

  typedef struct {
    string name;
    int    pattern;
    int    gapMax;
    bit    badTrailer;
    bit    expDone;
    bit    expError;
  } vec_t;

  wrRec_t            expQ[$];
  wrRec_t            gotQ[$];
  logic [WORD_W-1:0] words [TOTAL];
  vec_t              vecs [8];
  int                assertCount = 0;
  int                failCount = 0;

  always @(negedge clock) begin
    if (reset_n && wr_en) gotQ.push_back({wr_sel, wr_addr, wr_data});
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference stream: fills words[] and derives the expected write list from phase boundaries.
  task automatic buildModel(input int pattern, input bit badTrailer);
    logic [WORD_W-1:0] x;
    x = '0;
    for (int k = 0; k < TOTAL - 1; k++) begin
      case (pattern)
        0:       words[k] = '0;
        1:       words[k] = WORD_W'(k + 1);
        default: words[k] = $urandom;
      endcase
      x ^= words[k];
    end
    words[TOTAL-1] = badTrailer ? (x ^ 32'h1) : x;
    expQ.delete();
    for (int k = 0; k < TOTAL - 1; k++) begin
      if (k < N_LUT)             expQ.push_back({2'd0, ADDR_W'(k), words[k]});
      else if (k < N_LUT + N_SB) expQ.push_back({2'd1, ADDR_W'(k - N_LUT), words[k]});
      else                       expQ.push_back({2'd2, ADDR_W'(k - N_LUT - N_SB), words[k]});
    end
  endtask

  task automatic pulseStart();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic sendWord(input logic [WORD_W-1:0] w, input int gaps);
    int tries;
    repeat (gaps) begin
      @(negedge clock); cfg_valid = 1'b0;
    end
    @(negedge clock);
    cfg_valid = 1'b1;
    cfg_data  = w;
    tries = 0;
    while (!cfg_ready && tries < 50) begin
      @(negedge clock);
      tries++;
    end
    if (!cfg_ready) begin
      failCount++;
      $display("[TB] FAIL readyTimeout: got cfg_ready=0, expected 1 within 50 cycles");
    end
  endtask

  task automatic applyStimulus(input int gapMax);
    gotQ.delete();
    pulseStart();
    for (int k = 0; k < TOTAL; k++) begin
      sendWord(words[k], (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0);
    end
    @(negedge clock); cfg_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic checkWrites(input string tag);
    checkOutput({tag, ".writeCount"}, 64'(gotQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < gotQ.size()) checkOutput($sformatf("%s.write[%0d]", tag, i), 64'(gotQ[i]), 64'(expQ[i]));
    end
  endtask

  task automatic checkEnd(input string tag, input bit expDone, input bit expError);
    checkOutput({tag, ".done"}, 64'(done), 64'(expDone));
    checkOutput({tag, ".error"}, 64'(error), 64'(expError));
    checkOutput({tag, ".fabric_en"}, 64'(fabric_en), 64'(expDone));
    checkOutput({tag, ".word_count"}, 64'(word_count), 64'(TOTAL));
    checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
    checkOutput({tag, ".cfg_ready"}, 64'(cfg_ready), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"zeros",       0, 0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"countUp",     1, 0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"badTrailer",  1, 0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{"recover",     1, 0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"gapsCountUp", 1, 5, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"randomGaps",  2, 5, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{"randomBad",   2, 3, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{"randomGood",  2, 0, 1'b0, 1'b1, 1'b0};

    #1;
    checkOutput("reset.outputs",
                64'({cfg_ready, wr_en, wr_sel, wr_addr, busy, done, error, fabric_en, word_count}), 64'd0);
    checkOutput("reset.wr_data", 64'(wr_data), 64'd0);
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 8; v++) begin
      buildModel(vecs[v].pattern, vecs[v].badTrailer);
      applyStimulus(vecs[v].gapMax);
      checkEnd(vecs[v].name, vecs[v].expDone, vecs[v].expError);
      checkWrites(vecs[v].name);
    end

    // Start while mid-stream at word 20 must not disturb the load.
    buildModel(1, 1'b0);
    gotQ.delete();
    pulseStart();
    for (int k = 0; k < 20; k++) sendWord(words[k], 0);
    @(negedge clock); cfg_valid = 1'b0; start = 1'b1;
    @(negedge clock); start = 1'b0;
    checkOutput("midStart.word_count", 64'(word_count), 64'd20);
    checkOutput("midStart.wr_addr", 64'(wr_addr), 64'd8);
    checkOutput("midStart.busy", 64'(busy), 64'd1);
    for (int k = 20; k < TOTAL; k++) sendWord(words[k], 0);
    @(negedge clock); cfg_valid = 1'b0;
    @(negedge clock);
    checkEnd("midStart", 1'b1, 1'b0);
    checkWrites("midStart");

    // Asynchronous reset just after word 15 is accepted, then a clean reload.
    buildModel(1, 1'b0);
    gotQ.delete();
    pulseStart();
    for (int k = 0; k < 16; k++) sendWord(words[k], 0);
    @(posedge clock);
    #2;
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    #1;
    checkOutput("midReset.wr_en", 64'(wr_en), 64'd0);
    checkOutput("midReset.wr_sel", 64'(wr_sel), 64'd0);
    checkOutput("midReset.wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("midReset.wr_data", 64'(wr_data), 64'd0);
    checkOutput("midReset.ready_busy", 64'({cfg_ready, busy}), 64'd0);
    checkOutput("midReset.word_count", 64'(word_count), 64'd0);
    checkOutput("midReset.flags", 64'({done, error, fabric_en}), 64'd0);
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    checkOutput("midReset.partialWrites", 64'(gotQ.size()), 64'd15);
    applyStimulus(0);
    checkEnd("afterReset", 1'b1, 1'b0);
    checkWrites("afterReset");

    // Start from DONE drops the enable on the next edge and restarts the count.
    pulseStart();
    checkOutput("restart.fabric_en", 64'(fabric_en), 64'd0);
    checkOutput("restart.done", 64'(done), 64'd0);
    checkOutput("restart.word_count", 64'(word_count), 64'd0);
    checkOutput("restart.busy", 64'(busy), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
